// File: rtl/vga2_zdepth_test_if.sv
// ---------------------------------------------------------------------------
// vga2_zdepth_test_if
// Bus bundle for the scanline depth-test pipeline.
//   Fragment stream : in_valid/in_ready handshake carrying x, z, colour,
//                     depth function and depth-write enable.
//   Z-buffer port   : read strobe/address, read data (one cycle latency),
//                     write strobe/address/data and the start_of_line swap.
//   Pixel stream    : out_valid/out_ready handshake carrying x and colour.
// Modports:
//   master - the side that feeds fragments, owns the Z-buffer RAM and
//            consumes pixels (rasteriser / RAM / line-buffer writer)
//   slave  - the depth-test block itself
// ---------------------------------------------------------------------------
interface vga2_zdepth_test_if;
    // fragment stream
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_x;
    logic [11:0] in_z;
    logic [7:0]  in_color;
    logic [1:0]  depth_func;
    logic        zwrite_en;

    // Z-buffer RAM port
    logic        start_of_line;
    logic        read_enable;
    logic [9:0]  chkz_x;
    logic [11:0] fetched_z;
    logic        zbuf_write;
    logic [9:0]  zbuf_x_write;
    logic [11:0] zbuf_wdata;

    // surviving pixel stream
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_x;
    logic [7:0]  out_color;

    modport slave (
        input  in_valid, in_x, in_z, in_color, depth_func, zwrite_en,
        output in_ready,
        output start_of_line, read_enable, chkz_x,
        input  fetched_z,
        output zbuf_write, zbuf_x_write, zbuf_wdata,
        output out_valid, out_x, out_color,
        input  out_ready
    );

    modport master (
        output in_valid, in_x, in_z, in_color, depth_func, zwrite_en,
        input  in_ready,
        input  start_of_line, read_enable, chkz_x,
        output fetched_z,
        input  zbuf_write, zbuf_x_write, zbuf_wdata,
        input  out_valid, out_x, out_color,
        output out_ready
    );
endinterface

// File: rtl/vga2_zdepth_test.sv
// ---------------------------------------------------------------------------
// vga2_zdepth_test
// Per-scanline depth test. Fragments are accepted in S0 (which also issues
// the Z-buffer read), tested in S1 against the returned depth (with
// read-after-write forwarding from the S1 write-back), and survivors are
// held in the S2 output register. A two-state line FSM drains the pipeline
// before pulsing start_of_line, which swaps the Z-buffer halves.
// Ports:
//   clock        - single clock domain
//   reset        - asynchronous, active low
//   bus          - fragment stream, Z-buffer RAM port and pixel stream
//   new_line     - request a scanline change (pulse)
//   reject_count - fragments failing the test this line, saturating
// ---------------------------------------------------------------------------
module vga2_zdepth_test (
    input  logic                 clock,
    input  logic                 reset,
    vga2_zdepth_test_if.slave    bus,
    input  logic                 new_line,
    output logic [15:0]          reject_count
);
    localparam logic [1:0] DF_LESS   = 2'd0;
    localparam logic [1:0] DF_LEQUAL = 2'd1;
    localparam logic [1:0] DF_ALWAYS = 2'd2;
    localparam logic [1:0] DF_NEVER  = 2'd3;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } line_state_t;

    // Depth comparison; smaller z is nearer, unsigned compare.
    function automatic logic depth_pass(
        input logic [1:0]  func,
        input logic [11:0] frag_z,
        input logic [11:0] ref_z
    );
        logic result;
        case (func)
            DF_LESS:   result = (frag_z <  ref_z);
            DF_LEQUAL: result = (frag_z <= ref_z);
            DF_ALWAYS: result = 1'b1;
            DF_NEVER:  result = 1'b0;
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

    // line FSM
    line_state_t state_r;
    line_state_t state_next_s;
    logic        line_pending_s;
    logic        sol_s;

    // in_ready is held low until the first clock after reset release
    logic        ready_en_r;

    // S1 test/write stage
    logic        s1_valid_r;
    logic [9:0]  s1_x_r;
    logic [11:0] s1_z_r;
    logic [7:0]  s1_color_r;
    logic [1:0]  s1_func_r;
    logic        s1_zwe_r;
    logic        s1_fwd_hit_r;
    logic [11:0] s1_fwd_z_r;

    // S2 output register
    logic        out_valid_r;
    logic [9:0]  out_x_r;
    logic [7:0]  out_color_r;

    logic [15:0] reject_count_r;

    // pipeline control
    logic        s1_adv_s;
    logic        in_ready_s;
    logic        accept_s;
    logic [11:0] eff_z_s;
    logic        pass_s;
    logic        zwr_s;
    logic        fwd_hit_s;

    // Pipeline control, depth test and forwarding detection.
    always_comb begin
        s1_adv_s   = s1_valid_r & (~out_valid_r | bus.out_ready);
        in_ready_s = ready_en_r & ~line_pending_s & ~new_line & (~s1_valid_r | s1_adv_s);
        accept_s   = bus.in_valid & in_ready_s;
        // The RAM read issued in the same cycle as an equal-X write returns
        // the old depth, so the write data is carried along with the fragment.
        if (s1_fwd_hit_r) begin
            eff_z_s = s1_fwd_z_r;
        end else begin
            eff_z_s = bus.fetched_z;
        end
        pass_s    = depth_pass(s1_func_r, s1_z_r, eff_z_s);
        zwr_s     = s1_adv_s & pass_s & s1_zwe_r;
        fwd_hit_s = accept_s & zwr_s & (bus.in_x == s1_x_r);
    end

    assign bus.in_ready      = in_ready_s;
    assign bus.read_enable   = accept_s;
    assign bus.chkz_x        = bus.in_x;
    assign bus.zbuf_write    = zwr_s;
    assign bus.zbuf_x_write  = s1_x_r;
    assign bus.zbuf_wdata    = s1_z_r;
    assign bus.out_valid     = out_valid_r;
    assign bus.out_x         = out_x_r;
    assign bus.out_color     = out_color_r;
    assign bus.start_of_line = sol_s;
    assign reject_count      = reject_count_r;

    // Line FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Line FSM next state; a new_line seen while draining or in the pulse
    // cycle is absorbed by the request already pending.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (new_line) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_r && !out_valid_r) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: state_next_s = ST_RUN;
        endcase
    end

    // Line FSM outputs, decoded from registered state only.
    always_comb begin
        line_pending_s = 1'b0;
        sol_s          = 1'b0;
        case (state_r)
            ST_RUN: begin
                line_pending_s = 1'b0;
                sol_s          = 1'b0;
            end
            ST_DRAIN: begin
                line_pending_s = 1'b1;
                sol_s          = ~s1_valid_r & ~out_valid_r;
            end
            default: begin
                line_pending_s = 1'b0;
                sol_s          = 1'b0;
            end
        endcase
    end

    // Enables in_ready one clock after reset is released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // S1 register: loads the accepted fragment with its forwarding tag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_r   <= 1'b0;
            s1_x_r       <= 10'd0;
            s1_z_r       <= 12'd0;
            s1_color_r   <= 8'd0;
            s1_func_r    <= 2'd0;
            s1_zwe_r     <= 1'b0;
            s1_fwd_hit_r <= 1'b0;
            s1_fwd_z_r   <= 12'd0;
        end else if (accept_s) begin
            s1_valid_r   <= 1'b1;
            s1_x_r       <= bus.in_x;
            s1_z_r       <= bus.in_z;
            s1_color_r   <= bus.in_color;
            s1_func_r    <= bus.depth_func;
            s1_zwe_r     <= bus.zwrite_en;
            s1_fwd_hit_r <= fwd_hit_s;
            s1_fwd_z_r   <= s1_z_r;
        end else if (s1_adv_s) begin
            s1_valid_r   <= 1'b0;
        end else begin
            s1_valid_r   <= s1_valid_r;
        end
    end

    // S2 output register: takes passing fragments, empties on handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_x_r     <= 10'd0;
            out_color_r <= 8'd0;
        end else if (s1_adv_s && pass_s) begin
            out_valid_r <= 1'b1;
            out_x_r     <= s1_x_r;
            out_color_r <= s1_color_r;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Per-line reject counter, saturating, cleared by the line swap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reject_count_r <= 16'd0;
        end else if (sol_s) begin
            reject_count_r <= 16'd0;
        end else if (s1_adv_s && !pass_s && (reject_count_r != 16'hFFFF)) begin
            reject_count_r <= reject_count_r + 16'd1;
        end else begin
            reject_count_r <= reject_count_r;
        end
    end
endmodule

// File: tb/tb_vga2_zdepth_test.sv
// ---------------------------------------------------------------------------
// tb_vga2_zdepth_test
// Bench for vga2_zdepth_test. A Z-buffer RAM model (read-before-write, one
// cycle read latency, erased on start_of_line) sits on the bus. A reference
// model processes accepted fragments strictly in order against a per-line
// depth array and predicts pixels, depth writes and the reject count.
// ---------------------------------------------------------------------------
module tb_vga2_zdepth_test;
    logic        clock = 1'b0;
    logic        reset;
    logic        new_line;
    logic [15:0] reject_count;

    vga2_zdepth_test_if bus();

    vga2_zdepth_test dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .new_line     (new_line),
        .reject_count (reject_count)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- Z-buffer RAM model ----------------
    logic [11:0] zmem [0:1023];
    always @(posedge clock) begin
        if (bus.start_of_line) begin
            for (int i = 0; i < 1024; i++) zmem[i] <= 12'hFFF;
        end else begin
            if (bus.read_enable) bus.fetched_z <= zmem[bus.chkz_x];
            if (bus.zbuf_write)  zmem[bus.zbuf_x_write] <= bus.zbuf_wdata;
        end
    end

    // ---------------- out_ready driver ----------------
    logic rand_rdy  = 1'b0;
    logic force_rdy = 1'b1;
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            bus.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
        end
    end

    // ---------------- reference model + monitor ----------------
    logic [11:0] mz [0:1023];
    int unsigned pix_q[$];
    int unsigned wr_q[$];
    int unsigned wr_log[$];
    logic        got_pix [0:255];
    int          exp_rej = 0;
    int          cyc = 0;
    int          sol_cnt = 0;
    int          sol_cyc = 0;
    int          last_hs_cyc = 0;
    int          pix_cnt = 0;

    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                pix_q.delete();
                wr_q.delete();
                exp_rej = 0;
            end else begin
                if (bus.start_of_line) begin
                    sol_cnt++;
                    sol_cyc = cyc;
                    for (int i = 0; i < 1024; i++) mz[i] = 12'hFFF;
                    exp_rej = 0;
                end
                if (bus.zbuf_write) begin
                    wr_log.push_back({10'd0, bus.zbuf_x_write, bus.zbuf_wdata});
                    check("zwr_expected", (wr_q.size() != 0), 1);
                    if (wr_q.size() != 0)
                        check("zwr_addr_data", {10'd0, bus.zbuf_x_write, bus.zbuf_wdata}, wr_q.pop_front());
                end
                if (bus.out_valid && bus.out_ready) begin
                    pix_cnt++;
                    last_hs_cyc = cyc;
                    got_pix[bus.out_color] = 1'b1;
                    check("pix_expected", (pix_q.size() != 0), 1);
                    if (pix_q.size() != 0)
                        check("pix_x_color", {14'd0, bus.out_x, bus.out_color}, pix_q.pop_front());
                end
                if (bus.in_valid && bus.in_ready) begin
                    logic [11:0] rz;
                    logic        p;
                    check("read_en_on_accept", bus.read_enable, 1);
                    check("chkz_x", bus.chkz_x, bus.in_x);
                    rz = mz[bus.in_x];
                    case (bus.depth_func)
                        2'd0:    p = (bus.in_z < rz);
                        2'd1:    p = (bus.in_z <= rz);
                        2'd2:    p = 1'b1;
                        default: p = 1'b0;
                    endcase
                    if (p) begin
                        pix_q.push_back({14'd0, bus.in_x, bus.in_color});
                        if (bus.zwrite_en) begin
                            mz[bus.in_x] = bus.in_z;
                            wr_q.push_back({10'd0, bus.in_x, bus.in_z});
                        end
                    end else if (exp_rej < 65535) begin
                        exp_rej++;
                    end
                end else begin
                    check("read_en_idle", bus.read_enable, 0);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Entered and left at one time unit after a rising edge.
    task automatic send(input logic [9:0] x, input logic [11:0] z, input logic [7:0] c,
                        input logic [1:0] fn, input logic zwe);
        int n;
        n = 0;
        bus.in_valid = 1'b1; bus.in_x = x; bus.in_z = z; bus.in_color = c;
        bus.depth_func = fn; bus.zwrite_en = zwe;
        forever begin
            @(negedge clock);
            if (bus.in_ready) break;
            n++;
            if (n > 1000) begin
                check("send_accept", bus.in_ready, 1);
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic do_new_line();
        int n;
        @(posedge clock); #1;
        new_line = 1'b1;
        @(posedge clock); #1;
        new_line = 1'b0;
        n = 0;
        while (!bus.start_of_line && n < 100) begin
            @(negedge clock); n++;
        end
        check("new_line_sol", bus.start_of_line, 1);
        @(posedge clock); #1;
    endtask

    typedef struct {
        logic [9:0]  x;
        logic [11:0] z;
        logic [1:0]  fn;
        logic        zwe;
        logic        gap;
        logic        pass;
        logic        wr;
    } vec_t;
    vec_t tbl [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sol0, pix0, n;
        int unsigned exp_wr[$];

        // x, z, func, zwe, gap, pass, write -- against a freshly erased line
        tbl[0]  = '{10'd5,    12'h100, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{10'd7,    12'h200, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{10'd7,    12'h300, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0}; // forwarded reject
        tbl[3]  = '{10'd7,    12'h300, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0}; // RAM reject
        tbl[4]  = '{10'd7,    12'h200, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1}; // LEQUAL equal
        tbl[5]  = '{10'd12,   12'h050, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0}; // NEVER
        tbl[6]  = '{10'd12,   12'h060, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0}; // ALWAYS, no write
        tbl[7]  = '{10'd12,   12'h070, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{10'd12,   12'h070, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0}; // forwarded equal
        tbl[9]  = '{10'd12,   12'h070, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0}; // 2-cycle-old write
        tbl[10] = '{10'd0,    12'h000, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{10'd1023, 12'hFFE, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{10'd1023, 12'hFFE, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{10'd1023, 12'hFFF, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1};

        reset = 1'b0; new_line = 1'b0;
        bus.in_valid = 1'b0; bus.in_x = 10'd0; bus.in_z = 12'd0; bus.in_color = 8'd0;
        bus.depth_func = 2'd0; bus.zwrite_en = 1'b0;
        for (int i = 0; i < 256; i++) got_pix[i] = 1'b0;

        // reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_read_enable", bus.read_enable, 0);
        check("rst_zbuf_write", bus.zbuf_write, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sol", bus.start_of_line, 0);
        check("rst_reject_count", reject_count, 0);
        check("rst_out_x", bus.out_x, 0);
        check("rst_out_color", bus.out_color, 0);
        @(posedge clock); #1; reset = 1'b1;
        @(negedge clock); check("in_ready_release_cycle", bus.in_ready, 0);
        @(negedge clock); check("in_ready_after_release", bus.in_ready, 1);

        // idle new_line -> start_of_line exactly one cycle later
        @(posedge clock); #1; new_line = 1'b1;
        @(negedge clock);
        check("nl_in_ready", bus.in_ready, 0);
        check("nl_sol_t", bus.start_of_line, 0);
        @(posedge clock); #1; new_line = 1'b0;
        @(negedge clock); check("nl_sol_t1", bus.start_of_line, 1);
        @(negedge clock); check("nl_sol_t2", bus.start_of_line, 0);

        // single fragment latency against an erased line
        @(posedge clock); #1;
        bus.in_valid = 1'b1; bus.in_x = 10'd5; bus.in_z = 12'h100; bus.in_color = 8'h55;
        bus.depth_func = 2'd0; bus.zwrite_en = 1'b1;
        @(negedge clock);
        check("lat_read_enable", bus.read_enable, 1);
        check("lat_chkz_x", bus.chkz_x, 5);
        check("lat_zwr_t0", bus.zbuf_write, 0);
        @(posedge clock); #1; bus.in_valid = 1'b0;
        @(negedge clock);
        check("lat_zwr_t1", bus.zbuf_write, 1);
        check("lat_zwr_x", bus.zbuf_x_write, 5);
        check("lat_zwr_data", bus.zbuf_wdata, 12'h100);
        check("lat_out_valid_t1", bus.out_valid, 0);
        @(negedge clock);
        check("lat_out_valid_t2", bus.out_valid, 1);
        check("lat_out_x", bus.out_x, 5);
        check("lat_out_color", bus.out_color, 8'h55);
        check("lat_zwr_t2", bus.zbuf_write, 0);

        // table-driven vectors on a fresh line
        do_new_line();
        wr_log.delete();
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].gap) idle(1);
            send(tbl[i].x, tbl[i].z, 8'h10 + 8'(i), tbl[i].fn, tbl[i].zwe);
        end
        idle(6);
        for (int i = 0; i < 14; i++) begin
            check($sformatf("tbl_pass_%0d", i), got_pix[8'h10 + 8'(i)], tbl[i].pass);
            if (tbl[i].wr) exp_wr.push_back({10'd0, tbl[i].x, tbl[i].z});
        end
        check("tbl_write_count", wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            check($sformatf("tbl_write_%0d", i), wr_log[i], exp_wr[i]);
        check("tbl_rejects", reject_count, 5);

        // back-pressure: out_ready low while three fragments stream
        pix0 = pix_cnt;
        force_rdy = 1'b0;
        fork
            begin
                send(10'd20, 12'h010, 8'hA0, 2'd0, 1'b1);
                send(10'd21, 12'h010, 8'hA1, 2'd0, 1'b1);
                send(10'd22, 12'h010, 8'hA2, 2'd0, 1'b1);
            end
            begin
                n = 0;
                do begin @(negedge clock); n++; end while (!bus.out_valid && n < 50);
                check("stall_out_valid", bus.out_valid, 1);
                for (int k = 0; k < 3; k++) begin
                    check("stall_in_ready", bus.in_ready, 0);
                    check("stall_no_zwr", bus.zbuf_write, 0);
                    check("stall_hold_valid", bus.out_valid, 1);
                    @(negedge clock);
                end
                force_rdy = 1'b1;
            end
        join
        idle(6);
        check("stall_pixel_count", pix_cnt - pix0, 3);

        // new_line with two fragments in flight (second one rejected)
        force_rdy = 1'b0;
        send(10'd30, 12'h010, 8'hB0, 2'd0, 1'b1);
        send(10'd30, 12'h020, 8'hB1, 2'd0, 1'b1);
        sol0 = sol_cnt;
        new_line = 1'b1;
        bus.in_valid = 1'b1; bus.in_x = 10'd31; bus.in_z = 12'h001; bus.in_color = 8'hB2;
        @(negedge clock);
        check("nl_beats_in_valid", bus.read_enable, 0);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clock); #1;
            new_line = (k == 2);
            if (k == 3) force_rdy = 1'b1;
            @(negedge clock);
            check("drain_in_ready", bus.in_ready, 0);
            if (bus.start_of_line) begin
                n = 1;
                check("pre_sol_rejects", reject_count, 6);
                break;
            end
        end
        check("drain_sol_seen", n, 1);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        @(negedge clock);
        check("post_sol_rejects", reject_count, 0);
        idle(10);
        check("single_sol_pulse", sol_cnt - sol0, 1);
        check("sol_after_last_hs", sol_cyc, last_hs_cyc + 1);

        // randomized traffic against the reference model
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(10'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)), 8'($urandom),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
        end
        rand_rdy = 1'b0;
        force_rdy = 1'b1;
        idle(10);
        check("rand_pix_drained", pix_q.size(), 0);
        check("rand_wr_drained", wr_q.size(), 0);
        check("rand_rejects", reject_count, exp_rej);

        // reset asserted mid-stream
        bus.in_valid = 1'b1; bus.in_x = 10'd40; bus.in_z = 12'h005; bus.in_color = 8'hC0;
        bus.depth_func = 2'd2; bus.zwrite_en = 1'b1;
        idle(3);
        @(posedge clock); #3;
        check("pre_rst_out_valid", bus.out_valid, 1);
        check("pre_rst_zwr", bus.zbuf_write, 1);
        reset = 1'b0;
        #1;
        check("arst_in_ready", bus.in_ready, 0);
        check("arst_read_enable", bus.read_enable, 0);
        check("arst_zbuf_write", bus.zbuf_write, 0);
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_sol", bus.start_of_line, 0);
        check("arst_reject_count", reject_count, 0);
        check("arst_out_x", bus.out_x, 0);
        check("arst_out_color", bus.out_color, 0);
        bus.in_valid = 1'b0;
        @(posedge clock); #1; reset = 1'b1;
        @(negedge clock); check("rearm_in_ready0", bus.in_ready, 0);
        @(negedge clock); check("rearm_in_ready1", bus.in_ready, 1);
        check("rearm_out_valid", bus.out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga2_zdepth_test.md
# vga2_zdepth_test

Per-scanline depth-test pipeline that drives the double-buffered scanline Z-buffer RAM as its initiator. It accepts rasterised pixel fragments `(x, z, colour)` and issues the Z-buffer read. It compares the returned depth against the fragment depth, writes back the winning depth, and forwards surviving pixels to the line-buffer writer. It also generates the `start_of_line` pulse that swaps the Z-buffer halves, and only does so once every fragment of the current line has fully drained.

## Interface
Parameters: none (widths fixed by the Z-buffer RAM: 10-bit X, 12-bit Z).
- `clock`  in  1  single clock domain
- `reset`  in  1  asynchronous, active-low (asserted when 0)
- `in_valid`  in  1  fragment valid
- `in_ready`  out  1  fragment accepted when `in_valid & in_ready`
- `in_x`  in  10  fragment X
- `in_z`  in  12  fragment depth; smaller is nearer
- `in_color`  in  8  fragment colour
- `depth_func`  in  2  sampled with the fragment; 0 LESS, 1 LEQUAL, 2 ALWAYS, 3 NEVER
- `zwrite_en`  in  1  sampled with the fragment; 0 inhibits the depth write-back
- `new_line`  in  1  pulse: request a scanline change
- `start_of_line`  out  1  one-cycle pulse to the Z-buffer RAM
- `read_enable`  out  1  Z-buffer read strobe
- `chkz_x`  out  10  Z-buffer read address
- `fetched_z`  in  12  Z-buffer read data, valid one cycle after `read_enable`
- `zbuf_write`  out  1  Z-buffer write strobe
- `zbuf_x_write`  out  10  write address
- `zbuf_wdata`  out  12  write depth
- `out_valid`  out  1  surviving pixel valid (registered)
- `out_ready`  in  1  downstream accept
- `out_x`  out  10  surviving pixel X
- `out_color`  out  8  surviving pixel colour
- `reject_count`  out  16  fragments failing the test since the last `start_of_line`; saturates at 0xFFFF

## Operation
- Pipeline stages:
  - S0 (accept/read): `read_enable = in_valid & in_ready` and `chkz_x = in_x`, both combinational.
  - S1 (test/write): registers hold x, z, colour, depth_func, zwrite_en and the forward flag.
  - S2: output register.
- S1 advances (`s1_adv`) when S1 is valid and (`!out_valid | out_ready`).
- `in_ready = !line_pending & !new_line & (!s1_valid | s1_adv)`.
- While S1 is stalled, `read_enable` stays 0. The RAM holds `fetched_z`, so the value is still correct when S1 resumes.
- Effective depth: `eff_z = fwd_hit ? fwd_z : fetched_z`.
- Pass rule, unsigned 12-bit compare:
  - LESS: `in_z < eff_z`
  - LEQUAL: `in_z <= eff_z`
  - ALWAYS: pass
  - NEVER: fail
- On `s1_adv`:
  - Pass: load S2 with x and colour.
  - Pass with zwrite_en set: `zbuf_write=1`, `zbuf_x_write=x`, `zbuf_wdata=z` in that same cycle.
  - Fail: increment `reject_count`; no output and no write.
- `zbuf_write` is never asserted except on `s1_adv`.
- Read-after-write forwarding:
  - Applies when an S0 read and an S1 write with equal X occur in the same cycle. The RAM then returns stale data.
  - The block latches `fwd_hit=1` and `fwd_z=zbuf_wdata` into S1 alongside the fragment; otherwise `fwd_hit=0`.
  - Writes two or more cycles earlier are already visible in the RAM and need no forwarding.
- Line-change FSM:
  - States: RUN, DRAIN.
  - A `new_line` pulse in RUN moves the FSM to DRAIN (`line_pending=1`).
  - In DRAIN, once `!s1_valid & !out_valid`, the block pulses `start_of_line` for one cycle, clears `reject_count`, and returns to RUN.
  - A `new_line` arriving during DRAIN or in the pulse cycle merges with the pending request; only one pulse results.
  - `new_line` beats a coincident `in_valid`: that fragment is not accepted.

## Timing
- Reset values:
  - Outputs `in_ready=0`, `read_enable=0`, `zbuf_write=0`, `out_valid=0`, `start_of_line=0`, `reject_count=0`, `out_x=0`, `out_color=0`.
  - Internal state: S1 empty, FSM in RUN.
  - `in_ready` rises the first cycle after reset deasserts.
- Reset asserted mid-line empties S1/S2 immediately. In-flight fragments are dropped without a Z write.
- Latency, with no stalls:
  - Accept at cycle t → `read_enable` at t.
  - S1 test and `zbuf_write` at t+1.
  - `out_valid` at t+2.
- Throughput is one fragment per cycle.
- `start_of_line` occurs no earlier than one cycle after the last S2 pixel is accepted.
- With the FSM already idle and the pipeline empty, `new_line` at cycle t gives `start_of_line` at t+1.

## Test plan
- Single fragment x=5, z=0x100, LESS, against a freshly erased buffer (0xFFF):
  - `read_enable`/`chkz_x=5` at t.
  - `zbuf_write` x=5 data=0x100 at t+1.
  - `out_valid` x=5 at t+2.
- Back-to-back fragments x=7 z=0x200, then x=7 z=0x300, LESS:
  - The second is rejected through forwarding; `reject_count=1`.
  - Only one write occurs (0x200).
- Same case with a one-cycle gap between the fragments: the second is rejected via the RAM. Then x=7 z=0x200 LEQUAL passes with `zbuf_wdata=0x200`.
- `out_ready` held low for 5 cycles with 3 fragments streamed:
  - `in_ready` drops, no `zbuf_write` occurs during the stall, and no fragment is lost or duplicated.
  - All three pixels emerge in order.
- `new_line` with 2 fragments in flight:
  - `in_ready=0` until drained.
  - `start_of_line` is a single pulse after the last `out_valid` handshake; `reject_count` reads 0 the next cycle.
  - A second `new_line` during drain produces no extra pulse.
- NEVER with `zwrite_en=0` and ALWAYS with `zwrite_en=0`:
  - NEVER: no output, counter increments.
  - ALWAYS: output appears with no `zbuf_write`.
  - Assert `reset` low mid-stream: all outputs return to their reset values asynchronously.
